// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: length codes, byte counts, FSM states.
package mem_ctrl_pkg;

  localparam logic [1:0] LenByte = 2'b00;
  localparam logic [1:0] LenHalf = 2'b01;
  localparam logic [1:0] LenWord = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StAck
  } state_e;

  // Codes 10 and 11 both mean a full word.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LenByte: return 3'd1;
      LenHalf: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_rr_arb.sv
// Two-port round-robin arbiter; the pointer moves past the granted port on each advance.
module mem_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  // ptr_q names the port preferred at the next grant.
  logic ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (adv) begin
      ptr_q <= gnt[0];
    end
  end

  always_comb begin
    gnt = 2'b00;
    if (ptr_q) begin
      if (req[1]) begin
        gnt = 2'b10;
      end else if (req[0]) begin
        gnt = 2'b01;
      end
    end else begin
      if (req[0]) begin
        gnt = 2'b01;
      end else if (req[1]) begin
        gnt = 2'b10;
      end
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: one write port and two arbitrated read ports onto an 8-bit
// synchronous RAM, moving 1, 2 or 4 bytes per transaction.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned MEM_ADDR_W = 17,
  parameter int unsigned R_PORT     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [R_PORT-1:0]     co_re,
  input  logic [32*R_PORT-1:0]  co_raddr,
  input  logic [2*R_PORT-1:0]   co_rlen,
  output logic [32*R_PORT-1:0]  co_din,
  output logic [R_PORT-1:0]     co_rack,
  input  logic                  co_we,
  input  logic [31:0]           co_waddr,
  input  logic [1:0]            co_wlen,
  input  logic [31:0]           co_dout,
  output logic                  co_wack,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_we,
  input  logic [7:0]            mem_rdata
);

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [2:0]            n_q, n_d;
  logic [MEM_ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rbuf_q, rbuf_d;
  logic [63:0]           din_q, din_d;
  logic                  rd_q, rd_d;
  logic                  port_q, port_d;
  logic [1:0]            gnt;
  logic                  arb_adv;
  logic [1:0]            byte_idx;

  mem_rr_arb u_arb (
    .clk (clk),
    .rst (rst),
    .req (co_re[1:0]),
    .adv (arb_adv),
    .gnt (gnt)
  );

  // Read data for address i arrives one cycle later, so counter value c captures byte c-1.
  assign byte_idx = cnt_q[1:0] - 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      n_q     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      din_q   <= '0;
      rd_q    <= 1'b0;
      port_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rbuf_q  <= rbuf_d;
      din_q   <= din_d;
      rd_q    <= rd_d;
      port_q  <= port_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rbuf_d  = rbuf_q;
    din_d   = din_q;
    rd_d    = rd_q;
    port_d  = port_q;
    arb_adv = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (co_we) begin
          state_d = StWrite;
          rd_d    = 1'b0;
          addr_d  = co_waddr[MEM_ADDR_W-1:0];
          n_d     = len_bytes(co_wlen);
          wdata_d = co_dout;
        end else if (co_re[1:0] != 2'b00) begin
          state_d = StRead;
          arb_adv = 1'b1;
          rd_d    = 1'b1;
          port_d  = gnt[1];
          addr_d  = gnt[1] ? co_raddr[32 +: MEM_ADDR_W] : co_raddr[0 +: MEM_ADDR_W];
          n_d     = len_bytes(gnt[1] ? co_rlen[3:2] : co_rlen[1:0]);
          rbuf_d  = '0;
        end
      end
      StWrite: begin
        if (cnt_q == n_q - 3'd1) begin
          state_d = StAck;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StRead: begin
        if (cnt_q != 3'd0) begin
          rbuf_d[{byte_idx, 3'b000} +: 8] = mem_rdata;
        end
        if (cnt_q == n_q) begin
          // Publish the whole word at once so co_din never shows a partial result.
          state_d = StAck;
          if (port_q) begin
            din_d[63:32] = rbuf_d;
          end else begin
            din_d[31:0] = rbuf_d;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    mem_we     = (state_q == StWrite);
    mem_addr   = '0;
    mem_wdata  = '0;
    if (state_q == StRead || state_q == StWrite) begin
      mem_addr = addr_q + MEM_ADDR_W'(cnt_q);
    end
    if (mem_we) begin
      mem_wdata = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
    end
    co_wack    = (state_q == StAck) && !rd_q;
    co_rack    = '0;
    co_rack[0] = (state_q == StAck) && rd_q && !port_q;
    co_rack[1] = (state_q == StAck) && rd_q && port_q;
    co_din     = din_q;
  end

  // Address bits above the RAM width are ignored by design.
  logic unused_bits;
  assign unused_bits = ^{co_waddr[31:MEM_ADDR_W], co_raddr[31:MEM_ADDR_W],
                         co_raddr[63:32+MEM_ADDR_W], gnt[0]};

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: batches of requests are planned against a byte-array model.
module tb_mem_ctrl;

  localparam int unsigned AW   = 17;
  localparam int unsigned SIZE = 1 << AW;
  localparam logic [31:0] MASK = SIZE - 1;

  typedef struct { logic [31:0] addr; logic [1:0] len; } req_t;
  typedef struct { bit is_wr; bit port; logic [31:0] data; int cyc; } exp_t;
  typedef struct { logic [AW-1:0] addr; logic [7:0] data; } bus_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    co_re = '0;
  logic [63:0]   co_raddr = '0;
  logic [3:0]    co_rlen = '0;
  logic [63:0]   co_din;
  logic [1:0]    co_rack;
  logic          co_we = 1'b0;
  logic [31:0]   co_waddr = '0;
  logic [1:0]    co_wlen = '0;
  logic [31:0]   co_dout = '0;
  logic          co_wack;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_we;
  logic [7:0]    mem_rdata = '0;

  logic [7:0] ram [0:SIZE-1] = '{default: 8'h00};
  logic [7:0] ref_mem [0:SIZE-1] = '{default: 8'h00};

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  bus_t bus_q[$];
  req_t rq0[$];
  req_t rq1[$];
  bit   rr = 1'b0;
  int   last_ack = -100;
  logic        b_we;
  logic [31:0] b_waddr;
  logic [1:0]  b_wlen;
  logic [31:0] b_wdata;
  logic [63:0] din_sh = '0;

  mem_ctrl #(.MEM_ADDR_W(AW), .R_PORT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .co_re     (co_re),
    .co_raddr  (co_raddr),
    .co_rlen   (co_rlen),
    .co_din    (co_din),
    .co_rack   (co_rack),
    .co_we     (co_we),
    .co_waddr  (co_waddr),
    .co_wlen   (co_wlen),
    .co_dout   (co_dout),
    .co_wack   (co_wack),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM seen by the DUT.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic int nb(input logic [1:0] len);
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [1:0] len);
    logic [31:0] r = '0;
    for (int i = 0; i < nb(len); i++) r[8*i +: 8] = ref_mem[(addr + i) & MASK];
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a = $urandom;
    if ($urandom_range(0, 7) == 0) a[AW-1:0] = 17'h1FFFF - 17'($urandom_range(0, 3));
    else a[AW-1:0] = 17'($urandom_range(0, 63));
    return a;
  endfunction

  task automatic present0();
    co_re[0] = 1'b1; co_raddr[31:0] = rq0[0].addr; co_rlen[1:0] = rq0[0].len;
  endtask

  task automatic present1();
    co_re[1] = 1'b1; co_raddr[63:32] = rq1[0].addr; co_rlen[3:2] = rq1[0].len;
  endtask

  // Plans the service order (write first, then round robin) and expected ack cycles, then drives.
  task automatic run_batch();
    int   raise, g, i0, i1, budget;
    bit   pick;
    req_t r;
    logic wa;
    logic [1:0] ra;
    logic [31:0] a;
    raise = cyc;
    if (b_we) begin
      g = max2(raise + 1, last_ack + 2);
      for (int i = 0; i < nb(b_wlen); i++) begin
        a = (b_waddr + i) & MASK;
        ref_mem[a] = b_wdata[8*i +: 8];
        bus_q.push_back('{a[AW-1:0], b_wdata[8*i +: 8]});
      end
      last_ack = g + nb(b_wlen);
      exp_q.push_back('{1'b1, 1'b0, 32'h0, last_ack});
    end
    i0 = 0; i1 = 0;
    while (i0 < rq0.size() || i1 < rq1.size()) begin
      if (rr == 1'b0) pick = (i0 < rq0.size()) ? 1'b0 : 1'b1;
      else pick = (i1 < rq1.size()) ? 1'b1 : 1'b0;
      if (pick) begin r = rq1[i1]; i1++; end
      else begin r = rq0[i0]; i0++; end
      g = max2(raise + 1, last_ack + 2);
      last_ack = g + nb(r.len) + 1;
      exp_q.push_back('{1'b0, pick, model_read(r.addr, r.len), last_ack});
      rr = ~pick;
    end
    co_we = b_we; co_waddr = b_waddr; co_wlen = b_wlen; co_dout = b_wdata;
    if (rq0.size() > 0) present0();
    if (rq1.size() > 0) present1();
    budget = 200;
    while ((co_we || co_re != 2'b00) && budget > 0) begin
      @(negedge clk);
      wa = co_wack; ra = co_rack;
      @(posedge clk); #1;
      if (wa) co_we = 1'b0;
      if (ra[0]) begin
        void'(rq0.pop_front());
        if (rq0.size() > 0) present0(); else co_re[0] = 1'b0;
      end
      if (ra[1]) begin
        void'(rq1.pop_front());
        if (rq1.size() > 0) present1(); else co_re[1] = 1'b0;
      end
      budget--;
    end
    if (budget == 0) begin
      check("batch_timeout", {62'h0, co_we, |co_re}, 64'h0);
      co_we = 1'b0; co_re = '0; rq0.delete(); rq1.delete();
    end
  endtask

  task automatic clear_batch();
    b_we = 1'b0; b_waddr = '0; b_wlen = '0; b_wdata = '0;
    rq0.delete(); rq1.delete();
  endtask

  // Monitor: pops expectations whenever the DUT acknowledges or strobes a RAM write.
  initial begin
    exp_t e;
    bus_t b;
    forever begin
      @(negedge clk);
      if (rst) begin
        din_sh = '0;
      end else begin
        if (co_wack || co_rack != 2'b00) begin
          if (exp_q.size() == 0) begin
            check("unexpected_ack", {61'h0, co_wack, co_rack}, 64'h0);
          end else begin
            e = exp_q.pop_front();
            check("ack_kind", {61'h0, co_wack, co_rack},
                  e.is_wr ? 64'h4 : (e.port ? 64'h2 : 64'h1));
            check("ack_cycle", 64'(cyc), 64'(e.cyc));
            if (!e.is_wr) begin
              if (e.port) din_sh[63:32] = e.data;
              else din_sh[31:0] = e.data;
            end
          end
        end
        check("co_din", co_din, din_sh);
        if (mem_we) begin
          if (bus_q.size() == 0) begin
            check("unexpected_mem_we", 64'(mem_addr), 64'h0);
          end else begin
            b = bus_q.pop_front();
            check("wr_addr", 64'(mem_addr), 64'(b.addr));
            check("wr_data", 64'(mem_wdata), 64'(b.data));
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_rack", 64'(co_rack), 64'h0);
    check("rst_wack", 64'(co_wack), 64'h0);
    check("rst_din", co_din, 64'h0);
    check("rst_mem_we", 64'(mem_we), 64'h0);
    check("rst_mem_addr", 64'(mem_addr), 64'h0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Word write then word read on port 1.
    clear_batch();
    b_we = 1'b1; b_waddr = 32'h100; b_wlen = 2'b10; b_wdata = 32'h11223344;
    run_batch();
    clear_batch();
    rq1.push_back('{32'h100, 2'b10});
    run_batch();
    check("word_readback", co_din[63:32], 64'h11223344);

    // Both ports held: grants alternate 0, 1, 0.
    clear_batch();
    rq0.push_back('{32'h100, 2'b00});
    rq0.push_back('{32'h101, 2'b01});
    rq1.push_back('{32'h102, 2'b10});
    run_batch();

    // Byte read on port 0.
    clear_batch();
    rq0.push_back('{32'h102, 2'b00});
    run_batch();
    check("byte_read", co_din[31:0], 64'h22);

    // Simultaneous write and read of the same word: write first.
    clear_batch();
    b_we = 1'b1; b_waddr = 32'h200; b_wlen = 2'b11; b_wdata = 32'hCAFEF00D;
    rq1.push_back('{32'h200, 2'b10});
    run_batch();
    check("raw_order", co_din[63:32], 64'hCAFEF00D);

    // Half-word write at the top of the RAM wraps to address 0.
    clear_batch();
    b_we = 1'b1; b_waddr = 32'hABC1FFFF; b_wlen = 2'b01; b_wdata = 32'h0000BEEF;
    run_batch();
    check("wrap_hi", 64'(ram[17'h1FFFF]), 64'hEF);
    check("wrap_lo", 64'(ram[17'h00000]), 64'hBE);
    clear_batch();
    rq0.push_back('{32'h0001FFFF, 2'b01});
    run_batch();

    // Reset during the third byte of a word write.
    begin
      int c;
      c = cyc;
      co_we = 1'b1; co_waddr = 32'h300; co_wlen = 2'b10; co_dout = 32'hA1B2C3D4;
      for (int i = 0; i < 2; i++) begin
        ref_mem[32'h300 + i] = co_dout[8*i +: 8];
        bus_q.push_back('{17'(32'h300 + i), co_dout[8*i +: 8]});
      end
      repeat (3) @(posedge clk);
      #1;
      check("rst_pre_we", 64'(mem_we), 64'h1);
      #1;
      rst = 1'b1;
      co_we = 1'b0;
      #1;
      check("rst_async_we", 64'(mem_we), 64'h0);
      check("rst_mid_wack", 64'(co_wack), 64'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      rr = 1'b0;
      last_ack = -100;
      check("rst_partial_bytes", {32'h0, ram[32'h303], ram[32'h302], ram[32'h301], ram[32'h300]},
            {32'h0, ref_mem[32'h303], ref_mem[32'h302], ref_mem[32'h301], ref_mem[32'h300]});
      c = c + 0;
    end
    @(posedge clk); #1;
    clear_batch();
    rq1.push_back('{32'h300, 2'b10});
    run_batch();

    // Randomized traffic.
    for (int t = 0; t < 80; t++) begin
      int kind;
      clear_batch();
      kind = $urandom_range(0, 3);
      b_we = (kind == 0 || kind == 3);
      b_waddr = rand_addr(); b_wlen = 2'($urandom); b_wdata = $urandom;
      if (kind == 1) begin
        if ($urandom_range(0, 1) == 1) rq1.push_back('{rand_addr(), 2'($urandom)});
        else rq0.push_back('{rand_addr(), 2'($urandom)});
      end else if (kind == 2) begin
        for (int i = 0; i < $urandom_range(1, 2); i++) rq0.push_back('{rand_addr(), 2'($urandom)});
        for (int i = 0; i < $urandom_range(1, 2); i++) rq1.push_back('{rand_addr(), 2'($urandom)});
      end else if (kind == 3) begin
        if ($urandom_range(0, 1) == 1) rq1.push_back('{b_waddr, 2'($urandom)});
        else rq0.push_back('{b_waddr, 2'($urandom)});
      end
      run_batch();
    end

    repeat (5) @(posedge clk);
    check("exp_drained", 64'(exp_q.size()), 64'h0);
    check("bus_drained", 64'(bus_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
